fetch_stage: RTL

- Instruction fetch stage plus IF/ID pipeline register for the RV32I core.
- Holds the PC and fetches from instruction memory using a req/valid handshake.
- Registers the returned word and its PC into IF/ID. The opcode field goes directly to the downstream control decoder (`control`).
- Handles pipeline stall, flush and branch redirect, including redirects that arrive while a memory response is still outstanding.

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage and IF/ID pipeline register.
// Owns the PC, drives a req/valid instruction-memory port and feeds opcode to control.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic [6:0]      opcode
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic [XLEN-1:0] skid_q, skid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            req_q, req_d;
    ifid_t           ifid_q, ifid_d;

    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc_inc;
    logic            rsp;

    // Low target bits are masked rather than sliced so the whole port is consumed.
    assign tgt    = branch_target & ~XLEN'(3);
    assign pc_inc = pc_q + XLEN'(4);
    // A response only counts if a request is actually outstanding.
    assign rsp    = imem_valid && req_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        redir_d   = redir_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        ifid_d    = ifid_q;

        case (state_q)
            S_FETCH: begin
                if (branch_taken) begin
                    ifid_d.valid = 1'b0;
                    ifid_d.instr = NOP_INSTR;
                    // With a fetch in flight the address must stay put until it returns.
                    if (rsp || !req_q) begin
                        pc_d = tgt;
                    end else begin
                        redir_d = tgt;
                        state_d = S_DRAIN;
                    end
                end else if (flush) begin
                    ifid_d.valid = 1'b0;
                    ifid_d.instr = NOP_INSTR;
                    if (rsp) pc_d = pc_inc;
                end else if (stall) begin
                    if (rsp) begin
                        skid_d    = imem_rdata;
                        skid_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end else if (rsp) begin
                    ifid_d.instr = imem_rdata;
                    ifid_d.pc    = pc_q;
                    ifid_d.valid = 1'b1;
                    pc_d         = pc_inc;
                end
            end

            S_HOLD: begin
                if (branch_taken) begin
                    ifid_d.valid = 1'b0;
                    ifid_d.instr = NOP_INSTR;
                    pc_d         = tgt;
                    state_d      = S_FETCH;
                end else if (flush) begin
                    ifid_d.valid = 1'b0;
                    ifid_d.instr = NOP_INSTR;
                    pc_d         = pc_inc;
                    state_d      = S_FETCH;
                end else if (!stall) begin
                    ifid_d.instr = skid_q;
                    ifid_d.pc    = skid_pc_q;
                    ifid_d.valid = 1'b1;
                    pc_d         = pc_inc;
                    state_d      = S_FETCH;
                end
            end

            S_DRAIN: begin
                if (imem_valid) begin
                    pc_d    = branch_taken ? tgt : redir_q;
                    state_d = S_FETCH;
                end else if (branch_taken) begin
                    redir_d = tgt;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        req_d = (state_d != S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            redir_q      <= '0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            req_q        <= 1'b0;
            ifid_q.pc    <= '0;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            redir_q   <= redir_d;
            skid_q    <= skid_d;
            skid_pc_q <= skid_pc_d;
            req_q     <= req_d;
            ifid_q    <= ifid_d;
        end
    end

    // In DRAIN the PC is left at the outstanding address, so it doubles as imem_addr.
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_instr = ifid_q.instr;
    assign if_id_valid = ifid_q.valid;
    assign opcode      = ifid_q.instr[6:0];

endmodule
